// File: rtl/lcd_text_driver.sv
// HD44780 16x2 text driver: power-on init, then continuous two-line refresh
// from a 32-entry character source addressed by index.
module lcd_text_driver #(
  parameter int POWERON_WAIT = 1_000_000,
  parameter int SETUP        = 4,
  parameter int E_HIGH       = 25,
  parameter int CMD_WAIT     = 2_500,
  parameter int CLEAR_WAIT   = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  output logic [4:0] index,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    S_PWR,
    S_FETCH,
    S_SETUP,
    S_EHI,
    S_WAIT
  } state_t;

  localparam logic [20:0] PW_L  = 21'(POWERON_WAIT - 1);
  localparam logic [20:0] SU_L  = 21'(SETUP - 1);
  localparam logic [20:0] EH_L  = 21'(E_HIGH - 1);
  localparam logic [20:0] CW_L  = 21'(CMD_WAIT - 1);
  localparam logic [20:0] CLR_L = 21'(CLEAR_WAIT - 1);

  state_t      state, state_n;
  logic [20:0] cnt, cnt_n;
  logic [4:0]  index_n;
  logic        e_n, rs_n, init_n, frame_n;
  logic [7:0]  data_n;
  logic [1:0]  ptr, ptr_n;
  logic        is_char, is_char_n;
  logic [20:0] wait_last;
  logic [1:0]  ptr_inc;

  function automatic logic [7:0] init_cmd(input logic [1:0] p);
    logic [7:0] c;
    c = 8'h01;
    unique case (p)
      2'd0: c = 8'h38;
      2'd1: c = 8'h0C;
      2'd2: c = 8'h06;
      2'd3: c = 8'h01;
    endcase
    return c;
  endfunction

  assign lcd_rw    = 1'b0;
  assign ptr_inc   = ptr + 2'd1;
  // Only the last init command (clear) needs the long settle time
  assign wait_last = (!init_done && ptr == 2'd3) ? CLR_L : CW_L;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 21'd1;
    index_n   = index;
    e_n       = lcd_e;
    rs_n      = lcd_rs;
    data_n    = lcd_data;
    init_n    = init_done;
    frame_n   = 1'b0;
    ptr_n     = ptr;
    is_char_n = is_char;
    unique case (state)
      S_PWR: begin
        if (cnt == PW_L) begin
          state_n = S_SETUP;
          data_n  = 8'h38;
          rs_n    = 1'b0;
          ptr_n   = 2'd0;
        end
      end
      S_FETCH: begin
        if (cnt == 21'd1) begin
          state_n = S_SETUP;
          data_n  = char_in;
          rs_n    = 1'b1;
        end
      end
      S_SETUP: begin
        if (cnt == SU_L) begin
          state_n = S_EHI;
          e_n     = 1'b1;
        end
      end
      S_EHI: begin
        if (cnt == EH_L) begin
          state_n = S_WAIT;
          e_n     = 1'b0;
        end
      end
      S_WAIT: begin
        if (cnt == wait_last) begin
          if (!init_done) begin
            state_n = S_SETUP;
            rs_n    = 1'b0;
            if (ptr == 2'd3) begin
              init_n = 1'b1;
              data_n = 8'h80;
            end else begin
              ptr_n  = ptr_inc;
              data_n = init_cmd(ptr_inc);
            end
          end else if (!is_char) begin
            state_n   = S_FETCH;
            is_char_n = 1'b1;
          end else begin
            index_n = index + 5'd1;
            if (index == 5'd15 || index == 5'd31) begin
              state_n   = S_SETUP;
              rs_n      = 1'b0;
              is_char_n = 1'b0;
              data_n    = (index == 5'd15) ? 8'hC0 : 8'h80;
              frame_n   = (index == 5'd31);
            end else begin
              state_n = S_FETCH;
            end
          end
        end
      end
      default: state_n = S_PWR;
    endcase
    if (state_n != state) cnt_n = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_PWR;
      cnt        <= '0;
      index      <= '0;
      lcd_e      <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_data   <= 8'h00;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
      ptr        <= 2'd0;
      is_char    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      index      <= index_n;
      lcd_e      <= e_n;
      lcd_rs     <= rs_n;
      lcd_data   <= data_n;
      init_done  <= init_n;
      frame_done <= frame_n;
      ptr        <= ptr_n;
      is_char    <= is_char_n;
    end
  end

endmodule

// File: tb/tb_lcd_text_driver.sv
// Directed bench for lcd_text_driver: init order, frame bytes via scoreboard,
// frame period, fetch update and asynchronous reset.
module tb_lcd_text_driver;

  logic       clk;
  logic       rst;
  logic [7:0] char_in;
  logic [4:0] index;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;
  logic       init_done;
  logic       frame_done;

  int checks;
  int errors;
  int ec;
  int hold_bad;
  logic [7:0] mem [32];
  logic [8:0] exp_q [$];
  logic       prev_e;
  logic [7:0] prev_data;

  lcd_text_driver #(
    .POWERON_WAIT(50),
    .SETUP(2),
    .E_HIGH(3),
    .CMD_WAIT(10),
    .CLEAR_WAIT(40)
  ) dut (
    .clk(clk),
    .rst(rst),
    .char_in(char_in),
    .index(index),
    .lcd_e(lcd_e),
    .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw),
    .lcd_data(lcd_data),
    .init_done(init_done),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered string generator model
  always @(posedge clk) char_in <= mem[index];

  always @(posedge clk or negedge rst)
    if (!rst) ec <= 0;
    else ec <= ec + 1;

  always @(negedge clk) begin
    if (rst && lcd_e && prev_e && lcd_data != prev_data)
      hold_bad <= hold_bad + 1;
    prev_e    <= lcd_e;
    prev_data <= lcd_data;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] c5);
    string s;
    s = "12:34:56";
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++)
      exp_q.push_back({1'b1, (i == 5) ? c5 : 8'h20});
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 16; i < 32; i++)
      exp_q.push_back({1'b1, (i < 24) ? s[i-16] : 8'h20});
  endtask

  task automatic pop_fall(input string tag);
    int n;
    bit seen;
    logic [8:0] e;
    n = 0;
    seen = 0;
    while (n < 3000) begin
      @(negedge clk);
      n++;
      if (lcd_e) seen = 1;
      else if (seen) break;
    end
    e = exp_q.pop_front();
    chk({tag, "_tmo"}, 32'(n < 3000), 1);
    chk(tag, {23'd0, lcd_rs, lcd_data}, {23'd0, e});
  endtask

  task automatic power_on(input string tag);
    int n;
    int bad;
    n = 0;
    bad = 0;
    @(negedge clk);
    rst = 1'b1;
    while (!lcd_e && n < 200) begin
      @(negedge clk);
      n++;
      if (ec < 50 && (lcd_data != 0 || lcd_rs || index != 0 ||
                      init_done || frame_done || lcd_rw))
        bad++;
    end
    chk({tag, "_quiet"}, bad, 0);
    chk({tag, "_rise_cyc"}, ec, 52);
    chk({tag, "_rise_byte"}, {lcd_rs, lcd_data}, 9'h038);
  endtask

  int n;
  int hi;
  int fall_ec;
  int t1;
  int t2;
  logic [4:0] last_idx;

  initial begin
    checks = 0;
    errors = 0;
    hold_bad = 0;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h20;
    begin
      string s;
      s = "12:34:56";
      for (int i = 0; i < 8; i++) mem[16+i] = s[i];
    end
    repeat (3) @(negedge clk);
    chk("rst_outs", {index, lcd_e, lcd_rs, lcd_rw, lcd_data,
                     init_done, frame_done}, 0);

    power_on("pwr");
    hi = 0;
    while (lcd_e && hi < 20) begin
      @(negedge clk);
      hi++;
    end
    chk("e_high_len", hi, 3);
    chk("init0", {lcd_rs, lcd_data}, 9'h038);

    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h006);
    exp_q.push_back(9'h001);
    pop_fall("init1");
    pop_fall("init2");
    pop_fall("init3");
    fall_ec = ec;
    n = 0;
    while (!init_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("clear_gap", ec - fall_ec, 40);
    chk("after_clear", {lcd_rs, lcd_data}, 9'h080);

    push_frame(8'h20);
    for (int i = 0; i < 34; i++) pop_fall($sformatf("f1_%0d", i));

    n = 0;
    last_idx = index;
    while (!frame_done && n < 200) begin
      last_idx = index;
      @(negedge clk);
      n++;
    end
    t1 = ec;
    chk("wrap_prev", last_idx, 31);
    chk("wrap_idx", index, 0);
    chk("wrap_byte", {lcd_rs, lcd_data}, 9'h080);
    mem[5] = 8'h41;
    @(negedge clk);
    chk("fd_width", frame_done, 0);

    push_frame(8'h41);
    for (int i = 0; i < 34; i++) pop_fall($sformatf("f2_%0d", i));
    n = 0;
    while (!frame_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    t2 = ec;
    chk("period", t2 - t1, 574);
    chk("hold_data", hold_bad, 0);

    n = 0;
    while (!(lcd_e && lcd_rs && index >= 3) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("find_ehi", 32'(n < 300), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst", {lcd_e, lcd_data, index, init_done, lcd_rs}, 0);
    repeat (2) @(negedge clk);
    power_on("rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_text_driver.md
# lcd_text_driver

Downstream consumer of the 32-character string generator: sweeps a 5-bit character index, fetches the ASCII byte it returns, and drives an HD44780-compatible 16x2 character LCD over its 8-bit parallel bus. Performs the power-on init sequence once, then refreshes both lines continuously.

## Interface
- POWERON_WAIT, 1_000_000: cycles idle after reset before the first bus write (20 ms at 50 MHz).
- SETUP, 4: cycles `lcd_rs`/`lcd_data` are stable with `lcd_e` low before each E rise.
- E_HIGH, 25: cycles `lcd_e` is held high per write.
- CMD_WAIT, 2_500: cycles `lcd_e` is low after E fall for normal commands and characters.
- CLEAR_WAIT, 100_000: post-E wait for the clear command (0x01).
- All parameters are at least 1 and below 2^21. The timing counter is 21 bits.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- char_in  in  8  ASCII byte from the string generator. It is registered there and valid 1 cycle after `index` changes.
- index  out  5  character address presented to the string generator.
- lcd_e  out  1  LCD enable strobe.
- lcd_rs  out  1  register select: 0 = command, 1 = data.
- lcd_rw  out  1  constant 0 (write only).
- lcd_data  out  8  LCD data bus.
- init_done  out  1  high after the clear command's wait completes; stays high until reset.
- frame_done  out  1  one-cycle pulse after the wait of character 31 completes.

## Operation
- Reset values: `index`=0, `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=0x00, `init_done`=0, `frame_done`=0.
- States: PWR_WAIT → INIT (cmd ptr 0..3) → REFRESH loop. The REFRESH loop is: LINE_CMD → FETCH → WRITE per character.
- PWR_WAIT: count POWERON_WAIT cycles with all outputs at reset values.
- INIT: write the commands 0x38 (8-bit, 2-line), 0x0C (display on, cursor off), 0x06 (increment, no shift), 0x01 (clear).
  - 0x01 uses CLEAR_WAIT. All other commands use CMD_WAIT.
  - `lcd_rs`=0 for every INIT write.
- REFRESH:
  - Write command 0x80, then characters for `index` 0..15.
  - Write command 0xC0, then characters for `index` 16..31.
  - Pulse `frame_done`, then repeat from 0x80.
  - The clear command is never reissued during refresh.
- Character fetch: set `index`, then wait 2 cycles (FETCH). Latch `char_in` into `lcd_data` with `lcd_rs`=1 at the start of SETUP.
  - `char_in` is passed through unmodified; no range checking.
- Bus write sequence: SETUP cycles with E low, then E_HIGH cycles with E high, then CMD_WAIT or CLEAR_WAIT cycles with E low.
- `lcd_data`/`lcd_rs` change only at the start of a SETUP phase. They hold through the wait until the next SETUP.
- `index` wraps 31 → 0 at the end of a frame. It is held during LINE_CMD writes.

## Timing
- The first rising edge of `lcd_e` occurs POWERON_WAIT+SETUP cycles after the first clk edge with `rst` high.
- Command write length: SETUP+E_HIGH+wait cycles. Character write length: 2+SETUP+E_HIGH+CMD_WAIT cycles.
- Frame period (distance between `frame_done` pulses): 2·(SETUP+E_HIGH+CMD_WAIT) + 32·(2+SETUP+E_HIGH+CMD_WAIT) cycles.
- `init_done` rises in the cycle the clear wait ends. It coincides with the start of the first 0x80 SETUP.
- `rst` asserted at any time, including mid-E-pulse: all outputs go to reset values immediately (asynchronous). After release the block restarts from PWR_WAIT, including full init.
- `char_in` changes outside FETCH have no effect on the bus.

## Test plan
All scenarios use POWERON_WAIT=50, SETUP=2, E_HIGH=3, CMD_WAIT=10, CLEAR_WAIT=40.

- **Reset and power-on:** release `rst`.
  - All outputs stay at reset values for 50 cycles.
  - `lcd_e` first rises at cycle 52 with `lcd_data`=0x38 and `lcd_rs`=0.
  - E stays high exactly 3 cycles.
- **Init sequence:** monitor E falling edges.
  - Bytes are 0x38, 0x0C, 0x06, 0x01, all with `rs`=0.
  - Gap from the 0x01 E fall to the next SETUP start is 40 cycles.
  - `init_done` rises at that point and the next byte is 0x80.
- **Frame content:** model string generator outputs 0x20 for index 0..15, "12:34:56" for index 16..23, and 0x20 after that.
  - Captured bytes at E fall are 0x80, 16×0x20, 0xC0, 0x31 0x32 0x3A 0x33 0x34 0x3A 0x35 0x36, 8×0x20.
  - `rs`=1 only for character writes.
- **Frame period and wrap:** consecutive `frame_done` pulses are exactly 574 cycles apart.
  - Each pulse is 1 cycle wide.
  - `index` goes 31 → 0 and the next byte is 0x80 (not 0x01).
- **Fetch latency:** change the model's output for index 5 between frames.
  - The new value appears on the bus in the next frame.
  - `lcd_data` never changes while `lcd_e`=1.
- **Reset mid-operation:** assert `rst` during an E-high phase of a character write.
  - `lcd_e`, `lcd_data`, `index`, and `init_done` go to 0 the same cycle.
  - After release, E first rises again at cycle 52 with 0x38.
